sprite_line_buffer_mc: RTL and testbench

Parametrised sprite line buffer, successor to the fixed 3-buffer, 4bpp, 96 MHz/32 MHz line buffer. The sprite fetcher pushes 8-pixel planar words, and the block serialises them into a draw buffer. The scan side reads the display buffer under CE_PIX and clears each location behind the read.
- Adds over the previous generation: configurable depth and bit widths, horizontal flip, first-wins/last-wins priority, line-length clipping, a power-up clear sweep and a late-line status.
- Runs on one clock; the scan side uses a clock enable only.

---
 rtl/sprite_line_buffer_mc.sv | 160 ++++++++++++++++
 tb/tb_sprite_line_buffer_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_buffer_mc.sv
// Rotating sprite line buffers: fetcher words are serialised into the draw buffer
// while the scan side reads the display buffer and clears each location behind it.
module sprite_line_buffer_mc #(
  parameter int PLANES     = 4,
  parameter int COLOR_W    = 4,
  parameter int POS_W      = 10,
  parameter int LINE_LEN   = 512,
  parameter int NUM_BUFS   = 3,
  parameter int DRAW_AHEAD = 1,
  parameter int SCAN_START = 249,
  parameter int PRIO_FIRST = 0
) (
  input  logic                      CLK_96M,
  input  logic                      RESET_N,
  input  logic                      CE_PIX,
  input  logic                      V0,
  input  logic                      wr_req,
  output logic                      wr_ack,
  input  logic [8*PLANES-1:0]       data_in,
  input  logic [COLOR_W-1:0]        color_in,
  input  logic [POS_W-1:0]          position_in,
  input  logic                      flip_in,
  output logic [COLOR_W+PLANES-1:0] pixel_out,
  output logic                      ready,
  output logic                      late
);
  localparam int PIX_W  = COLOR_W + PLANES;
  localparam int DEPTH  = 1 << POS_W;
  localparam int TOTAL  = NUM_BUFS * DEPTH;
  localparam int ADDR_W = POS_W + 2;

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  state_t state, state_next;

  logic [PIX_W-1:0]    mem [TOTAL];
  logic [ADDR_W-1:0]   clr_addr;
  logic                v0_q, toggle;
  logic [1:0]          scan_buf, scan_buf_next, draw_buf;
  logic [POS_W-1:0]    scan_pos;
  logic [ADDR_W-1:0]   scan_addr;
  logic                scan_en, accept, emit;
  logic [3:0]          count;
  logic [2:0]          idx;
  logic [8*PLANES-1:0] data_q;
  logic [COLOR_W-1:0]  color_q;
  logic [POS_W-1:0]    pos_q;
  logic                flip_q;
  logic [PLANES-1:0]   pix_p0;
  logic [ADDR_W-1:0]   addr_p0, addr_p1, draw_addr;
  logic                we_p0, vld_p1, draw_we;
  logic [PIX_W-1:0]    pix_p1, draw_data;
  logic [PLANES-1:0]   rd_p1;

  function automatic logic [PLANES-1:0] pick_pixel(input logic [8*PLANES-1:0] d,
                                                   input logic fl, input logic [2:0] i);
    logic [PLANES-1:0] res;
    logic [7:0]        pl;
    logic [2:0]        b;
    res = '0;
    b = fl ? i : 3'd7 - i;
    for (int p = 0; p < PLANES; p++) begin
      pl = d[p*8 +: 8];
      res[p] = pl[b];
    end
    return res;
  endfunction

  always_comb begin
    state_next = state;
    if (state == S_CLEAR && clr_addr == ADDR_W'(TOTAL - 1)) state_next = S_RUN;
  end

  always_comb begin
    int sum;
    sum = int'(scan_buf) + DRAW_AHEAD;
    if (sum >= NUM_BUFS) sum = sum - NUM_BUFS;
    draw_buf      = 2'(sum);
    scan_buf_next = (scan_buf == 2'(NUM_BUFS - 1)) ? 2'd0 : scan_buf + 2'd1;
  end

  assign toggle    = V0 ^ v0_q;
  assign scan_addr = {scan_buf, scan_pos};
  assign scan_en   = ready && CE_PIX && !toggle;
  assign accept    = ready && (count == 4'd0) && (wr_req != wr_ack) && !toggle;
  assign emit      = (count != 4'd0) && !toggle;
  assign idx       = 3'(4'd8 - count);

  // Emit stage: one pixel per cycle from the registered word
  assign pix_p0  = pick_pixel(data_q, flip_q, idx);
  assign addr_p0 = {draw_buf, pos_q};
  assign we_p0   = emit && (pix_p0 != '0) && (int'(pos_q) < LINE_LEN);

  // Write stage: first-wins writes only after the stored pixel was seen transparent
  always_comb begin
    draw_we   = we_p0;
    draw_addr = addr_p0;
    draw_data = {color_q, pix_p0};
    if (PRIO_FIRST != 0) begin
      draw_we   = vld_p1 && (rd_p1 == '0);
      draw_addr = addr_p1;
      draw_data = pix_p1;
    end
  end

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      v0_q      <= 1'b0;
      scan_buf  <= '0;
      scan_pos  <= POS_W'(SCAN_START);
      ready     <= 1'b0;
      late      <= 1'b0;
      pixel_out <= '0;
      wr_ack    <= 1'b0;
      count     <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state  <= state_next;
      if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
      v0_q   <= V0;
      ready  <= (state == S_RUN);
      late   <= toggle && (count != 4'd0);
      vld_p1 <= we_p0;
      if (toggle) begin
        scan_buf <= scan_buf_next;
        scan_pos <= POS_W'(SCAN_START);
        count    <= '0;
      end else begin
        if (scan_en) begin
          pixel_out <= mem[scan_addr];
          scan_pos  <= scan_pos + 1'b1;
        end
        if (accept) begin
          count  <= 4'd8;
          wr_ack <= wr_req;
        end else if (count != 4'd0) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_96M) begin
    if (accept) begin
      data_q  <= data_in;
      color_q <= color_in;
      flip_q  <= flip_in;
      pos_q   <= position_in;
    end else if (emit) begin
      pos_q <= pos_q + 1'b1;
    end
    addr_p1 <= addr_p0;
    pix_p1  <= {color_q, pix_p0};
    rd_p1   <= mem[addr_p0][PLANES-1:0];
    if (state == S_CLEAR) mem[clr_addr] <= '0;
    if (scan_en) mem[scan_addr] <= '0;
    if (draw_we) mem[draw_addr] <= draw_data;
  end
endmodule

// File: tb/tb_sprite_line_buffer_mc.sv
// Directed bench for sprite_line_buffer_mc; a last-wins and a first-wins instance share stimulus.
module tb_sprite_line_buffer_mc;
  localparam int DEPTH      = 1024;
  localparam int SCAN_START = 249;

  logic        clk = 1'b0;
  logic        rst_n, ce_pix, v0, wr_req, flip_in;
  logic [31:0] data_in;
  logic [3:0]  color_in;
  logic [9:0]  position_in;
  logic        wr_ack0, wr_ack1, ready0, ready1, late0, late1;
  logic [7:0]  pix0, pix1;
  logic [7:0]  line0 [DEPTH];
  logic [7:0]  line1 [DEPTH];
  logic [7:0]  exp0 [DEPTH];
  logic [7:0]  exp1 [DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_line_buffer_mc #(.PRIO_FIRST(0)) dut0 (
    .CLK_96M(clk), .RESET_N(rst_n), .CE_PIX(ce_pix), .V0(v0),
    .wr_req(wr_req), .wr_ack(wr_ack0), .data_in(data_in), .color_in(color_in),
    .position_in(position_in), .flip_in(flip_in), .pixel_out(pix0),
    .ready(ready0), .late(late0));

  sprite_line_buffer_mc #(.PRIO_FIRST(1)) dut1 (
    .CLK_96M(clk), .RESET_N(rst_n), .CE_PIX(ce_pix), .V0(v0),
    .wr_req(wr_req), .wr_ack(wr_ack1), .data_in(data_in), .color_in(color_in),
    .position_in(position_in), .flip_in(flip_in), .pixel_out(pix1),
    .ready(ready1), .late(late1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle_line();
    v0 = ~v0;
    tick();
  endtask

  task automatic clear_exp();
    for (int i = 0; i < DEPTH; i++) begin
      exp0[i] = 8'h00;
      exp1[i] = 8'h00;
    end
  endtask

  task automatic scan_line();
    int p;
    p = SCAN_START;
    for (int k = 0; k < DEPTH; k++) begin
      ce_pix = 1'b1;
      tick();
      line0[p] = pix0;
      line1[p] = pix1;
      ce_pix = 1'b0;
      tick();
      p = (p + 1) % DEPTH;
    end
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] c,
                           input logic [9:0] pos, input logic f);
    int t;
    data_in = d; color_in = c; position_in = pos; flip_in = f;
    wr_req = ~wr_req;
    t = 0;
    while (wr_ack0 != wr_req && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (wr_ack0 !== wr_req || wr_ack1 !== wr_req) begin
      errors++;
      $display("FAIL push_ack got %b/%b expected %b", wr_ack0, wr_ack1, wr_req);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; ce_pix = 1'b0; v0 = 1'b0; wr_req = 1'b1;
    data_in = '0; color_in = '0; position_in = '0; flip_in = 1'b0;
    repeat (3) tick();
    checks++;
    if ({wr_ack0, wr_ack1, late0, late1, ready0, ready1} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ack=%b%b late=%b%b ready=%b%b expected all 0",
               wr_ack0, wr_ack1, late0, late1, ready0, ready1);
    end
    checks++;
    if (pix0 !== 8'h00 || pix1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_pixel got %h/%h expected 00", pix0, pix1);
    end
    rst_n = 1'b1;
    repeat (100) tick();
    cnt = 100;
    checks++;
    if (wr_ack0 !== 1'b0 || wr_ack1 !== 1'b0 || ready0 !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_ack got ack=%b%b ready=%b expected 0", wr_ack0, wr_ack1, ready0);
    end
    while (!ready0 && cnt < 5000) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 3 * 1024 + 1 || ready1 !== 1'b1) begin
      errors++;
      $display("FAIL ready_latency got %0d (ready1=%b) expected %0d", cnt, ready1, 3 * 1024 + 1);
    end
    cnt = 0;
    while (wr_ack0 != wr_req && cnt < 20) begin
      tick();
      cnt++;
    end
    checks++;
    if (wr_ack0 !== 1'b1 || wr_ack1 !== 1'b1) begin
      errors++;
      $display("FAIL pending_ack got %b/%b expected 1", wr_ack0, wr_ack1);
    end
    repeat (10) tick();
  endtask

  task automatic test_blank();
    toggle_line();
    toggle_line();
    clear_exp();
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL blank x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_basic();
    push_word(32'h0000_00F0, 4'd5, 10'd100, 1'b0);
    toggle_line();
    clear_exp();
    for (int i = 100; i < 104; i++) begin exp0[i] = 8'h51; exp1[i] = 8'h51; end
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL basic x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
    toggle_line();
    toggle_line();
    toggle_line();
    clear_exp();
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL clear_after_read x=%0d got %h/%h expected 00", i, line0[i], line1[i]);
      end
    end
  endtask

  task automatic test_flip();
    push_word(32'h0000_00F0, 4'd5, 10'd100, 1'b1);
    toggle_line();
    clear_exp();
    for (int i = 104; i < 108; i++) begin exp0[i] = 8'h51; exp1[i] = 8'h51; end
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL flip x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_priority();
    push_word(32'hFFFF_FFFF, 4'd1, 10'd200, 1'b0);
    push_word(32'hFFFF_FFFF, 4'd2, 10'd200, 1'b0);
    toggle_line();
    clear_exp();
    for (int i = 200; i < 208; i++) begin exp0[i] = 8'h2F; exp1[i] = 8'h1F; end
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL priority x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_clip();
    push_word(32'hFFFF_FFFF, 4'd3, 10'd508, 1'b0);
    push_word(32'hFFFF_FFFF, 4'd4, 10'd1020, 1'b0);
    toggle_line();
    clear_exp();
    for (int i = 508; i < 512; i++) begin exp0[i] = 8'h3F; exp1[i] = 8'h3F; end
    for (int i = 0; i < 4; i++) begin exp0[i] = 8'h4F; exp1[i] = 8'h4F; end
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL clip x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  task automatic test_late();
    int t;
    data_in = 32'h0000_00FF; color_in = 4'd6; position_in = 10'd300; flip_in = 1'b0;
    wr_req = ~wr_req;
    t = 0;
    while (wr_ack0 != wr_req && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if (wr_ack0 !== wr_req) begin
      errors++;
      $display("FAIL late_first_ack got %b expected %b", wr_ack0, wr_req);
    end
    tick();
    data_in = 32'h0000_FF00; color_in = 4'd7; position_in = 10'd400;
    wr_req = ~wr_req;
    tick();
    v0 = ~v0;
    tick();
    checks++;
    if (late0 !== 1'b1 || late1 !== 1'b1) begin
      errors++;
      $display("FAIL late_pulse got %b/%b expected 1", late0, late1);
    end
    checks++;
    if (wr_ack0 === wr_req || wr_ack1 === wr_req) begin
      errors++;
      $display("FAIL late_held_ack got %b/%b expected %b", wr_ack0, wr_ack1, ~wr_req);
    end
    tick();
    checks++;
    if (late0 !== 1'b0 || late1 !== 1'b0) begin
      errors++;
      $display("FAIL late_width got %b/%b expected 0", late0, late1);
    end
    checks++;
    if (wr_ack0 !== wr_req || wr_ack1 !== wr_req) begin
      errors++;
      $display("FAIL late_second_ack got %b/%b expected %b", wr_ack0, wr_ack1, wr_req);
    end
    repeat (12) tick();
    clear_exp();
    exp0[300] = 8'h61; exp1[300] = 8'h61;
    exp0[301] = 8'h61; exp1[301] = 8'h61;
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL late_abort x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
    toggle_line();
    clear_exp();
    for (int i = 400; i < 408; i++) begin exp0[i] = 8'h72; exp1[i] = 8'h72; end
    scan_line();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (line0[i] !== exp0[i] || line1[i] !== exp1[i]) begin
        errors++;
        $display("FAIL late_pending x=%0d got %h/%h expected %h/%h", i, line0[i], line1[i], exp0[i], exp1[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blank();
    test_basic();
    test_flip();
    test_priority();
    test_clip();
    test_late();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
